button_press_classifier: RTL

//   Downstream stage of the button debouncer: consumes its debounced, synchronous button level.

---
 rtl/button_press_classifier.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into short / long / double press pulses.
// Optional BTN_AUTOREPEAT_EN macro enables repeat_press pulses while a long press is held.
module button_press_classifier #(
  parameter int LONG_CYCLES   = 8,
  parameter int GAP_CYCLES    = 6,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_WAIT_GAP  = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_THR = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] GAP_THR  = CNT_W'(GAP_CYCLES);

  // Thresholds must be reachable by the counter and leave room for the +1 step.
  generate
    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        LONG_CYCLES >= (1 << CNT_W) || GAP_CYCLES >= (1 << CNT_W) ||
        REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_params
      $error("button_press_classifier: illegal threshold parameters");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             repeat_q, repeat_d;
  logic             busy_q;
  logic             rise;

  assign rise = btn_level & ~btn_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = S_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        // Release is checked first so it beats the long threshold on the same edge.
        if (!btn_level) begin
          state_d = S_WAIT_GAP;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_THR) begin
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_GAP: begin
        if (btn_level) begin
          double_d = 1'b1;
          state_d  = S_PRESS2;
          cnt_d    = '0;
        end else if (cnt_q == GAP_THR) begin
          short_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESS2: begin
        cnt_d = '0;
        if (!btn_level) state_d = S_IDLE;
      end
      S_LONG_HELD: begin
        if (!btn_level) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_q == CNT_W'(REPEAT_CYCLES)) begin
            repeat_d = 1'b1;
            cnt_d    = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b1;  // a button held through reset must not look like a fresh press
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_level;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      repeat_q <= repeat_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign repeat_press = repeat_q;
  assign busy         = busy_q;

endmodule
